mem_responder: RTL and testbench

Multi-cycle, word-addressed memory responder that sits on the far side of the CPU's instruction/data memory port. It accepts one request at a time through a ready/enable handshake, commits writes and returns read data a fixed number of cycles later. It is the memory model the pipelined and cached CPU phases are built and verified against.

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int BLOCK_BYTES = 16;
    localparam int LAT_W       = 4;
    localparam int BEAT_W      = $clog2(BLOCK_WORDS);

endpackage

// File: rtl/mem_array.sv
// Word-wide storage: synchronous write, combinational read, never reset.
module mem_array #(
    parameter int AW = 15,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // Commit a write at the end of the cycle it is enabled in
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle word-addressed memory responder with fixed response latency.
// Optional 8-word read bursts are enabled by defining MEMRESP_BURST_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_data,
`ifdef MEMRESP_BURST_EN
    input  logic              req_burst,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              wr_done
);

    localparam int WA_W = ADDR_W - 1;

    state_t            r_state, w_state_nxt;
    logic [LAT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt;
    logic [WA_W-1:0]   r_widx;
    logic [15:0]       r_wdata;
    logic              r_wr;

    logic              w_accept;
    logic              w_zero;
    logic              w_burst_rd;
    logic              w_we;
    logic              w_load;
    logic              w_wdone;
    logic [BEAT_W-1:0] w_ld_beat;
    logic [WA_W-1:0]   w_ridx;
    logic [15:0]       w_rdata;
    logic              w_unused_addr0;

    // Byte-select bit of the address has no meaning for a word array
    assign w_unused_addr0 = req_addr[0];

`ifdef MEMRESP_BURST_EN
    logic r_burst;

    // Burst flag captured with the request; bursts only apply to reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_burst <= 1'b0;
        else if (w_accept)
            r_burst <= req_burst;
    end

    assign w_burst_rd = r_burst && !r_wr;
`else
    assign w_burst_rd = 1'b0;
`endif

    assign w_zero = (r_cnt == '0);

    // Next state, countdown, beat index and ready; accept overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        req_ready   = 1'b0;
        w_we        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = !rst;
            ST_WAIT: begin
                if (w_zero) begin
                    w_we = r_wr;
                    if (w_burst_rd) begin
                        w_state_nxt = ST_BEAT;
                        w_beat_nxt  = BEAT_W'(1);
                    end else begin
                        req_ready   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_BEAT: begin
                w_beat_nxt = r_beat + 1'b1;
                if (r_beat == BEAT_W'(BLOCK_WORDS - 1)) begin
                    req_ready   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_accept = req_en && req_ready;
        if (w_accept) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LAT_W'(LATENCY - 1);
        end
    end

    // State, counters and request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_widx  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_widx  <= req_addr[ADDR_W-1:1];
                r_wdata <= req_data;
                r_wr    <= req_wr;
            end
        end
    end

    // Outputs are registered, so each beat is fetched one cycle ahead:
    // the first beat when the countdown reads 1, later beats while the
    // previous one is on the bus.
    always_comb begin
        w_load    = 1'b0;
        w_wdone   = 1'b0;
        w_ld_beat = '0;
        if (r_state == ST_WAIT && r_cnt == LAT_W'(1)) begin
            w_load  = !r_wr;
            w_wdone = r_wr;
        end else if (r_state == ST_WAIT && w_zero && w_burst_rd) begin
            w_load    = 1'b1;
            w_ld_beat = BEAT_W'(1);
        end else if (r_state == ST_BEAT && r_beat != BEAT_W'(BLOCK_WORDS - 1)) begin
            w_load    = 1'b1;
            w_ld_beat = r_beat + 1'b1;
        end
    end

    assign w_ridx = w_burst_rd ? {r_widx[WA_W-1:BEAT_W], w_ld_beat} : r_widx;

    // Registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            wr_done   <= 1'b0;
        end else begin
            rsp_valid <= w_load;
            wr_done   <= w_wdone;
            if (w_load) begin
                rsp_data <= w_rdata;
                rsp_addr <= {w_ridx, 1'b0};
            end
        end
    end

    mem_array #(
        .AW (WA_W),
        .DW (16)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (r_wdata),
        .i_raddr (w_ridx),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic checked
// against a plain word-array model of memory.
module tb_mem_responder;

    localparam int L  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_en;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_data;
    logic          req_burst;
    logic          req_ready;
    logic          rsp_valid;
    logic [15:0]   rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          wr_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [0:127];

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W  (AW),
        .LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
`ifdef MEMRESP_BURST_EN
        .req_burst (req_burst),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .wr_done   (wr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_ready", 32'(req_ready), 32'(1));
            chk("idle_valid", 32'(rsp_valid), 32'(0));
            chk("idle_wr_done", 32'(wr_done), 32'(0));
        end
    endtask

    // Issue one request in the current cycle (called at a negedge where the
    // responder should be ready) and check every cycle through its response.
    task automatic issue(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                         input bit burst, input bit hold);
        int          nb;
        int          i;
        logic [15:0] ea;
        nb = (burst && !wr) ? 8 : 1;
        chk("accept_ready", 32'(req_ready), 32'(1));
        req_en    = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        req_burst = burst;
        for (int k = 1; k < L + nb; k++) begin
            @(negedge clk);
            if (!hold || k == L) begin
                req_en    = 1'b0;
                req_wr    = 1'($urandom);
                req_addr  = 16'($urandom);
                req_data  = 16'($urandom);
                req_burst = 1'($urandom);
            end
            if (k < L) begin
                chk("busy_ready", 32'(req_ready), 32'(0));
                chk("busy_valid", 32'(rsp_valid), 32'(0));
                chk("busy_wr_done", 32'(wr_done), 32'(0));
            end else begin
                i = k - L;
                chk("rsp_wr_done", 32'(wr_done), 32'(wr));
                chk("rsp_valid", 32'(rsp_valid), 32'(!wr));
                if (!wr) begin
                    if (nb == 1) ea = {addr[15:1], 1'b0};
                    else         ea = (addr & 16'hFFF0) + 16'(2 * i);
                    chk("rsp_addr", 32'(rsp_addr), 32'(ea));
                    chk("rsp_data", 32'(rsp_data), 32'(mdl[ea[7:1]]));
                end
                chk("rsp_ready", 32'(req_ready), 32'(i == nb - 1));
            end
        end
        if (wr) mdl[addr[7:1]] = data;
    endtask

    initial begin
        bit          wr, bu, ho;
        logic [15:0] a, d;

        rst = 1'b1; req_en = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; req_burst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'(0));
        chk("reset_valid", 32'(rsp_valid), 32'(0));
        chk("reset_data", 32'(rsp_data), 32'(0));
        chk("reset_addr", 32'(rsp_addr), 32'(0));
        chk("reset_wr_done", 32'(wr_done), 32'(0));
        rst = 1'b0;
        idle(2);

        // Give every word in the exercised region a known value
        for (int w = 0; w < 128; w++)
            issue(1'b1, 16'(2 * w), 16'($urandom), 1'b0, 1'b0);
        idle(1);

        // Write then read the same word, accepted back to back
        issue(1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0);
        issue(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
        chk("wr_rd_value", 32'(rsp_data), 32'h1234);
        idle(1);

        // Odd byte address maps onto the same word
        issue(1'b1, 16'h0031, 16'hAAAA, 1'b0, 1'b0);
        issue(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);
        chk("odd_value", 32'(rsp_data), 32'hAAAA);
        idle(1);

        // Back-to-back reads
        issue(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);
        idle(2);

        // Request held while busy yields one response only
        issue(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1);
        idle(3);

        // Reset in the middle of a write aborts it
        issue(1'b1, 16'h0010, 16'h5555, 1'b0, 1'b0);
        idle(1);
        chk("rst_pre_ready", 32'(req_ready), 32'(1));
        req_en = 1'b1; req_wr = 1'b1; req_addr = 16'h0010; req_data = 16'hBEEF; req_burst = 1'b0;
        @(negedge clk);
        req_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'(0));
        chk("midrst_valid", 32'(rsp_valid), 32'(0));
        chk("midrst_data", 32'(rsp_data), 32'(0));
        chk("midrst_addr", 32'(rsp_addr), 32'(0));
        chk("midrst_wr_done", 32'(wr_done), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        issue(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        chk("rst_abort_value", 32'(rsp_data), 32'h5555);
        idle(1);

`ifdef MEMRESP_BURST_EN
        for (int w = 0; w < 8; w++)
            issue(1'b1, 16'(16'h0040 + 2 * w), 16'(16'h0100 + w), 1'b0, 1'b0);
        issue(1'b0, 16'h0046, 16'h0000, 1'b1, 1'b0);
        chk("burst_last_data", 32'(rsp_data), 32'h0107);
        chk("burst_last_addr", 32'(rsp_addr), 32'h004E);
        idle(1);
        // Burst flag on a write is a single write
        issue(1'b1, 16'h0052, 16'h7777, 1'b1, 1'b0);
        issue(1'b0, 16'h0052, 16'h0000, 1'b0, 1'b0);
        chk("burst_wr_value", 32'(rsp_data), 32'h7777);
        idle(1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            a  = 16'($urandom_range(0, 255));
            d  = 16'($urandom);
`ifdef MEMRESP_BURST_EN
            bu = !wr && ($urandom_range(0, 3) == 0);
`else
            bu = 1'b0;
`endif
            ho = ($urandom_range(0, 3) == 0);
            issue(wr, a, d, bu, ho);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
